// File: rtl/ship_pkg.sv
// Shared ship definitions: FSM and direction encodings plus the default
// playfield geometry used by the renderer and collision logic.
package ship_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } ship_state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_L    = 2'd1,
        DIR_R    = 2'd2
    } ship_dir_e;

    localparam int SHIP_LEFT_LIMIT  = 0;
    localparam int SHIP_RIGHT_LIMIT = 19;
    localparam int SHIP_RESET_POS   = 5;

endpackage

// File: rtl/ship_step_alu.sv
// Combinational one-column step: applies a direction to a position with
// saturate or wrap at the limits and reports the resulting at-limit flags.
module ship_step_alu
    import ship_pkg::*;
#(
    parameter int X_WIDTH     = 5,
    parameter int LEFT_LIMIT  = SHIP_LEFT_LIMIT,
    parameter int RIGHT_LIMIT = SHIP_RIGHT_LIMIT,
    parameter bit WRAP        = 1'b0
) (
    input  logic [X_WIDTH-1:0] i_pos,
    input  ship_dir_e          i_dir,
    output logic [X_WIDTH-1:0] o_pos,
    output logic               o_at_left,
    output logic               o_at_right
);

    // One spare bit keeps the +/-1 arithmetic clear of X_WIDTH overflow.
    localparam logic [X_WIDTH:0] LL  = (X_WIDTH+1)'(LEFT_LIMIT);
    localparam logic [X_WIDTH:0] RL  = (X_WIDTH+1)'(RIGHT_LIMIT);
    localparam logic [X_WIDTH:0] ONE = (X_WIDTH+1)'(1);

    logic [X_WIDTH:0] pos_ext;
    logic [X_WIDTH:0] next_ext;

    always_comb begin
        pos_ext  = {1'b0, i_pos};
        next_ext = pos_ext;
        case (i_dir)
            DIR_L: begin
                if (pos_ext <= LL) next_ext = WRAP ? RL : LL;
                else               next_ext = pos_ext - ONE;
            end
            DIR_R: begin
                if (pos_ext >= RL) next_ext = WRAP ? LL : RL;
                else               next_ext = pos_ext + ONE;
            end
            default: next_ext = pos_ext;
        endcase
    end

    assign o_pos      = next_ext[X_WIDTH-1:0];
    assign o_at_left  = (next_ext == LL);
    assign o_at_right = (next_ext == RL);

endmodule

// File: rtl/ship_motion_ctrl.sv
// Player-ship column controller: first press steps at once, a held button
// auto-repeats after REPEAT_DELAY ticks and then every REPEAT_PERIOD ticks.
module ship_motion_ctrl
    import ship_pkg::*;
#(
    parameter int X_WIDTH       = 5,
    parameter int LEFT_LIMIT    = SHIP_LEFT_LIMIT,
    parameter int RIGHT_LIMIT   = SHIP_RIGHT_LIMIT,
    parameter int RESET_POS     = SHIP_RESET_POS,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 3,
    parameter bit WRAP          = 1'b0
) (
    input  logic               i_clk_36MHz,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_left_debounced,
    input  logic               i_right_debounced,
    output logic [X_WIDTH-1:0] o_ship_x,
    output logic               o_moving,
    output logic               o_at_left,
    output logic               o_at_right
);

    localparam int MAX_RELOAD = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW         = $clog2(MAX_RELOAD + 1);

    localparam logic [CW-1:0]      DELAY_RL  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0]      PERIOD_RL = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
    localparam logic [X_WIDTH-1:0] RESET_X   = X_WIDTH'(RESET_POS);
    localparam logic               RESET_AL  = (RESET_POS == LEFT_LIMIT);
    localparam logic               RESET_AR  = (RESET_POS == RIGHT_LIMIT);

    if (LEFT_LIMIT >= RIGHT_LIMIT) begin : g_chk_limits
        $error("ship_motion_ctrl: LEFT_LIMIT must be below RIGHT_LIMIT");
    end
    if (RESET_POS < LEFT_LIMIT || RESET_POS > RIGHT_LIMIT) begin : g_chk_reset
        $error("ship_motion_ctrl: RESET_POS outside the playfield");
    end
    if (RIGHT_LIMIT >= (2 ** X_WIDTH)) begin : g_chk_width
        $error("ship_motion_ctrl: RIGHT_LIMIT does not fit in X_WIDTH");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_chk_repeat
        $error("ship_motion_ctrl: repeat timings must be at least 1");
    end

    ship_state_e        state_q, state_d;
    ship_dir_e          dir_q, dir_d;
    ship_dir_e          dir_req;
    ship_dir_e          step_dir;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [X_WIDTH-1:0] x_q, x_d;
    logic               moving_q, moving_d;
    logic               at_left_q, at_left_d;
    logic               at_right_q, at_right_d;
    logic [X_WIDTH-1:0] alu_pos;
    logic               alu_at_left, alu_at_right;

    ship_step_alu #(
        .X_WIDTH     (X_WIDTH),
        .LEFT_LIMIT  (LEFT_LIMIT),
        .RIGHT_LIMIT (RIGHT_LIMIT),
        .WRAP        (WRAP)
    ) u_step_alu (
        .i_pos      (x_q),
        .i_dir      (step_dir),
        .o_pos      (alu_pos),
        .o_at_left  (alu_at_left),
        .o_at_right (alu_at_right)
    );

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        step_dir   = DIR_NONE;
        x_d        = x_q;
        at_left_d  = at_left_q;
        at_right_d = at_right_q;
        // Both buttons together cancel out, same as neither.
        if (i_left_debounced && !i_right_debounced)      dir_req = DIR_L;
        else if (i_right_debounced && !i_left_debounced) dir_req = DIR_R;
        else                                             dir_req = DIR_NONE;

        if (i_enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (dir_req != DIR_NONE) begin
                        step_dir = dir_req;
                        dir_d    = dir_req;
                        cnt_d    = DELAY_RL;
                        state_d  = ST_HOLD;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (dir_req == DIR_NONE) begin
                        state_d = ST_IDLE;
                        dir_d   = DIR_NONE;
                        cnt_d   = '0;
                    end else if (dir_req == dir_q) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - CNT_ONE;
                        end else begin
                            step_dir = dir_req;
                            cnt_d    = PERIOD_RL;
                            state_d  = ST_REPEAT;
                        end
                    end else begin
                        step_dir = dir_req;
                        dir_d    = dir_req;
                        cnt_d    = DELAY_RL;
                        state_d  = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    dir_d   = DIR_NONE;
                    cnt_d   = '0;
                end
            endcase
            x_d        = alu_pos;
            at_left_d  = alu_at_left;
            at_right_d = alu_at_right;
        end
        moving_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk_36MHz) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_NONE;
            cnt_q      <= '0;
            x_q        <= RESET_X;
            moving_q   <= 1'b0;
            at_left_q  <= RESET_AL;
            at_right_q <= RESET_AR;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            moving_q   <= moving_d;
            at_left_q  <= at_left_d;
            at_right_q <= at_right_d;
        end
    end

    assign o_ship_x   = x_q;
    assign o_moving   = moving_q;
    assign o_at_left  = at_left_q;
    assign o_at_right = at_right_q;

`ifdef FORMAL
    a_pos_range: assert property (@(posedge i_clk_36MHz)
        (int'(x_q) >= LEFT_LIMIT) && (int'(x_q) <= RIGHT_LIMIT));
    a_moving: assert property (@(posedge i_clk_36MHz)
        moving_q == (state_q != ST_IDLE));
    a_cnt_bound: assert property (@(posedge i_clk_36MHz)
        (state_q == ST_IDLE) ? (cnt_q == '0) :
        (state_q == ST_HOLD) ? (cnt_q <= DELAY_RL) : (cnt_q <= PERIOD_RL));
    a_hold_still: assert property (@(posedge i_clk_36MHz)
        (i_reset && !i_enable) |=> $stable(x_q));
`endif

endmodule

// File: tb/tb_ship_motion_ctrl.sv
// Bench for ship_motion_ctrl: a saturating and a wrapping instance share the
// same stimulus and are checked every cycle against a behavioural model.
module tb_ship_motion_ctrl;

    localparam int L_LIM = 0;
    localparam int R_LIM = 19;
    localparam int RST_X = 5;
    localparam int DLY   = 8;
    localparam int PER   = 3;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       left;
    logic       right;
    logic [4:0] x_sat, x_wr;
    logic       mv_sat, al_sat, ar_sat;
    logic       mv_wr, al_wr, ar_wr;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];

    // model state per instance: index 0 saturating, 1 wrapping
    int m_x[2];
    int m_st[2];
    int m_dir[2];
    int m_cnt[2];

    ship_motion_ctrl #(.WRAP(1'b0)) dut_sat (
        .i_clk_36MHz       (clk),
        .i_reset           (rst_n),
        .i_enable          (en),
        .i_left_debounced  (left),
        .i_right_debounced (right),
        .o_ship_x          (x_sat),
        .o_moving          (mv_sat),
        .o_at_left         (al_sat),
        .o_at_right        (ar_sat)
    );

    ship_motion_ctrl #(.WRAP(1'b1)) dut_wrap (
        .i_clk_36MHz       (clk),
        .i_reset           (rst_n),
        .i_enable          (en),
        .i_left_debounced  (left),
        .i_right_debounced (right),
        .o_ship_x          (x_wr),
        .o_moving          (mv_wr),
        .o_at_left         (al_wr),
        .o_at_right        (ar_wr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #14 clk = ~clk;

    function automatic logic [7:0] pack(input int x, input int st);
        return {5'(x), (st != 0), (x == L_LIM), (x == R_LIM)};
    endfunction

    task automatic model_update(input int k, input bit e, input bit l, input bit r, input bit rs);
        int  req;
        bit  do_step;
        if (!rs) begin
            m_x[k] = RST_X; m_st[k] = 0; m_dir[k] = 0; m_cnt[k] = 0;
        end else if (e) begin
            req     = (l && !r) ? 1 : ((r && !l) ? 2 : 0);
            do_step = 1'b0;
            if (m_st[k] == 0) begin
                if (req != 0) begin
                    do_step = 1'b1; m_dir[k] = req; m_cnt[k] = DLY - 1; m_st[k] = 1;
                end
            end else if (req == 0) begin
                m_st[k] = 0; m_dir[k] = 0; m_cnt[k] = 0;
            end else if (req == m_dir[k]) begin
                if (m_cnt[k] != 0) m_cnt[k] = m_cnt[k] - 1;
                else begin
                    do_step = 1'b1; m_cnt[k] = PER - 1; m_st[k] = 2;
                end
            end else begin
                do_step = 1'b1; m_dir[k] = req; m_cnt[k] = DLY - 1; m_st[k] = 1;
            end
            if (do_step) begin
                if (req == 1) m_x[k] = (m_x[k] == L_LIM) ? ((k == 1) ? R_LIM : L_LIM) : m_x[k] - 1;
                else          m_x[k] = (m_x[k] == R_LIM) ? ((k == 1) ? L_LIM : R_LIM) : m_x[k] + 1;
            end
        end
    endtask

    // driver: one clock with scoreboard push at drive and pop after the edge
    task automatic cycle(input bit e, input bit l, input bit r, input bit rs);
        logic [15:0] exp_w;
        logic [15:0] got_w;
        @(negedge clk);
        en = e; left = l; right = r; rst_n = rs;
        for (int k = 0; k < 2; k++) model_update(k, e, l, r, rs);
        exp_q.push_back({pack(m_x[0], m_st[0]), pack(m_x[1], m_st[1])});
        @(posedge clk);
        #1;
        got_w = {x_sat, mv_sat, al_sat, ar_sat, x_wr, mv_wr, al_wr, ar_wr};
        exp_w = exp_q.pop_front();
        total++;
        assert (got_w === exp_w) else begin
            bad++;
            $error("FAIL sb t=%0t got sat=%h wrap=%h exp sat=%h wrap=%h",
                   $time, got_w[15:8], got_w[7:0], exp_w[15:8], exp_w[7:0]);
        end
    endtask

    // one enable tick followed by an enable-low cycle
    task automatic tick(input bit l, input bit r);
        cycle(1'b1, l, r, 1'b1);
        cycle(1'b0, l, r, 1'b1);
    endtask

    task automatic chk(input string tag, input int got, input int exp_v);
        total++;
        assert (got === exp_v) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp_v);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; left = 1'b0; right = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_x[k] = RST_X; m_st[k] = 0; m_dir[k] = 0; m_cnt[k] = 0;
        end

        for (int i = 0; i < 3; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        chk("reset_x", int'(x_sat), 5);
        chk("reset_moving", int'(mv_sat), 0);
        chk("reset_at_left", int'(al_sat), 0);
        chk("reset_at_right", int'(ar_sat), 0);

        // right held: first step, delay, then repeat
        for (int i = 1; i <= 12; i++) begin
            tick(1'b0, 1'b1);
            if (i == 1)  chk("right_t1", int'(x_sat), 6);
            if (i == 8)  chk("right_t8", int'(x_sat), 6);
            if (i == 9)  chk("right_t9", int'(x_sat), 7);
            if (i == 12) chk("right_t12", int'(x_sat), 8);
        end
        tick(1'b0, 1'b0);
        chk("right_release_moving", int'(mv_sat), 0);

        // left taps from reset column
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0);
            chk("tap_moving", int'(mv_sat), 1);
            tick(1'b0, 1'b0);
            chk("tap_release", int'(mv_sat), 0);
        end
        chk("taps_x", int'(x_sat), 1);

        // left held into the limit: saturate vs wrap
        for (int i = 1; i <= 30; i++) begin
            tick(1'b1, 1'b0);
            if (i == 1) chk("lim_sat_t1", int'(x_sat), 0);
            if (i == 1) chk("lim_wrap_t1", int'(x_wr), 0);
            if (i == 9) chk("lim_wrap_t9", int'(x_wr), 19);
            if (i == 9) chk("lim_wrap_at_right", int'(ar_wr), 1);
            if (i == 12) chk("lim_wrap_t12", int'(x_wr), 18);
        end
        chk("lim_sat_end", int'(x_sat), 0);
        chk("lim_sat_at_left", int'(al_sat), 1);
        chk("lim_wrap_end", int'(x_wr), 12);
        tick(1'b0, 1'b0);

        // direction reversal out of REPEAT, then both buttons
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
        chk("rev_pre", int'(x_sat), 7);
        tick(1'b1, 1'b0);
        chk("rev_immediate", int'(x_sat), 6);
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b0);
        chk("rev_delay", int'(x_sat), 6);
        tick(1'b1, 1'b0);
        chk("rev_repeat", int'(x_sat), 5);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        chk("both_moving", int'(mv_sat), 0);
        chk("both_x", int'(x_sat), 5);

        // enable low while held, then reset mid-repeat
        for (int i = 0; i < 9; i++) tick(1'b0, 1'b1);
        for (int i = 0; i < 100; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1);
        chk("noen_x", int'(x_sat), 7);
        chk("noen_moving", int'(mv_sat), 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_mid_x", int'(x_sat), 5);
        chk("rst_mid_moving", int'(mv_sat), 0);
        tick(1'b0, 1'b1);
        chk("rst_fresh_right", int'(x_sat), 6);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) tick(1'b1, 1'b0);
        chk("left_repeat", int'(x_sat), 4);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst_left_x", int'(x_sat), 5);
        tick(1'b1, 1'b0);
        chk("rst_fresh_left", int'(x_sat), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
